// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, ALU, mux-select and control state definitions
package mips_pkg;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SLLI  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_LW    = 6'h04;
    localparam logic [5:0] OP_SW    = 6'h05;
    localparam logic [5:0] OP_BEQ   = 6'h06;
    localparam logic [5:0] OP_ADDI  = 6'h07;
    localparam logic [5:0] OP_SLTI  = 6'h08;
    localparam logic [5:0] OP_SLTIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0A;
    localparam logic [5:0] OP_XORI  = 6'h0B;

    localparam logic [3:0] ALU_FUNCT = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_ADD   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_XOR   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SLTU  = 4'b1000;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_REG = 1'b1;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_ALU   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_FAULT    = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_MEM     = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } opclass_t;

endpackage

// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - control/datapath/memory signal bundle for the multicycle controller
interface mc_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       sign_or_zero;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_fault;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, sign_or_zero, instr_done,
               illegal_op, mem_fault
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, sign_or_zero, instr_done,
               illegal_op, mem_fault
    );
endinterface

// File: rtl/mc_opclass_dec.sv
// rtl/mc_opclass_dec.sv - opcode to instruction class, I-type ALU op and extension mode
module mc_opclass_dec
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output opclass_t   opclass,
    output logic [3:0] alu_op_i,
    output logic       sign_or_zero_i
);

    always_comb begin
        opclass        = CLS_ILLEGAL;
        alu_op_i       = ALU_ADD;
        sign_or_zero_i = 1'b1;
        case (opcode)
            OP_ADD:   opclass = CLS_R;
            OP_SLLI:  begin opclass = CLS_I; alu_op_i = ALU_SLL;  sign_or_zero_i = 1'b0; end
            OP_ADDI:  begin opclass = CLS_I; alu_op_i = ALU_ADD;  end
            OP_SLTI:  begin opclass = CLS_I; alu_op_i = ALU_SLT;  end
            OP_SLTIU: begin opclass = CLS_I; alu_op_i = ALU_SLTU; end
            OP_ORI:   begin opclass = CLS_I; alu_op_i = ALU_OR;   sign_or_zero_i = 1'b0; end
            OP_XORI:  begin opclass = CLS_I; alu_op_i = ALU_XOR;  sign_or_zero_i = 1'b0; end
            OP_LW, OP_SW: opclass = CLS_MEM;
            OP_BEQ:       opclass = CLS_BRANCH;
            OP_J, OP_JAL: opclass = CLS_JUMP;
            default:      opclass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle MIPS-subset control FSM with memory handshake and timeout
module mc_control
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    mc_control_if.master       cif,
    output logic [STATE_W-1:0] state
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t           st;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             fault_q;
    logic [5:0]       dec_op;
    opclass_t         dec_cls;
    logic [3:0]       dec_alu_op;
    logic             dec_sign;
    logic             in_mem_st;
    logic             tmo_hit;

    // IR opcode is used live in DECODE and from the latched copy afterwards
    assign dec_op = (st == ST_DECODE) ? cif.opcode : op_q;

    mc_opclass_dec u_dec (
        .opcode         (dec_op),
        .opclass        (dec_cls),
        .alu_op_i       (dec_alu_op),
        .sign_or_zero_i (dec_sign)
    );

    assign in_mem_st = (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
    // Fault on the MEM_TIMEOUT-th consecutive wait cycle of one access
    assign tmo_hit   = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= ST_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else if (in_mem_st && !cif.mem_ready) begin
            if (tmo_hit) begin
                st      <= ST_FAULT;
                fault_q <= 1'b1;
            end else if (MEM_TIMEOUT != 0) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end else begin
            wait_cnt <= '0;
            case (st)
                ST_FETCH:  st <= ST_DECODE;
                ST_DECODE: begin
                    op_q <= cif.opcode;
                    case (dec_cls)
                        CLS_R:      st <= ST_EXEC_R;
                        CLS_I:      st <= ST_EXEC_I;
                        CLS_MEM:    st <= ST_MEM_ADDR;
                        CLS_BRANCH: st <= ST_BRANCH;
                        CLS_JUMP:   st <= ST_JUMP;
                        default:    st <= ST_FETCH;
                    endcase
                end
                ST_EXEC_R, ST_EXEC_I: st <= ST_WB_ALU;
                ST_MEM_ADDR: st <= (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD:   st <= ST_WB_MEM;
                ST_FAULT:    st <= ST_FAULT;
                default:     st <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        cif.mem_req      = 1'b0;
        cif.mem_we       = 1'b0;
        cif.iord         = 1'b0;
        cif.ir_write     = 1'b0;
        cif.pc_write     = 1'b0;
        cif.pc_src       = PCSRC_ALU;
        cif.reg_write    = 1'b0;
        cif.reg_dst      = REGDST_RT;
        cif.mem_to_reg   = M2R_ALUOUT;
        cif.alu_src_a    = SRCA_PC;
        cif.alu_src_b    = SRCB_REG;
        cif.alu_op       = ALU_FUNCT;
        cif.sign_or_zero = 1'b1;
        cif.instr_done   = 1'b0;
        cif.illegal_op   = 1'b0;
        if (!reset) begin
            case (st)
                ST_FETCH: begin
                    cif.mem_req   = 1'b1;
                    cif.alu_src_b = SRCB_FOUR;
                    cif.alu_op    = ALU_ADD;
                    cif.ir_write  = cif.mem_ready;
                    cif.pc_write  = cif.mem_ready;
                end
                ST_DECODE: begin
                    cif.alu_src_b = SRCB_IMM_SH2;
                    cif.alu_op    = ALU_ADD;
                    if (dec_cls == CLS_ILLEGAL) begin
                        cif.illegal_op = 1'b1;
                        cif.instr_done = 1'b1;
                    end
                end
                ST_EXEC_R: cif.alu_src_a = SRCA_REG;
                ST_EXEC_I: begin
                    cif.alu_src_a    = SRCA_REG;
                    cif.alu_src_b    = SRCB_IMM;
                    cif.alu_op       = dec_alu_op;
                    cif.sign_or_zero = dec_sign;
                end
                ST_MEM_ADDR: begin
                    cif.alu_src_a = SRCA_REG;
                    cif.alu_src_b = SRCB_IMM;
                    cif.alu_op    = ALU_ADD;
                end
                ST_MEM_RD: begin
                    cif.mem_req = 1'b1;
                    cif.iord    = 1'b1;
                end
                ST_MEM_WR: begin
                    cif.mem_req    = 1'b1;
                    cif.mem_we     = 1'b1;
                    cif.iord       = 1'b1;
                    cif.instr_done = cif.mem_ready;
                end
                ST_WB_ALU: begin
                    cif.reg_write  = 1'b1;
                    cif.reg_dst    = (dec_cls == CLS_R) ? REGDST_RD : REGDST_RT;
                    cif.instr_done = 1'b1;
                end
                ST_WB_MEM: begin
                    cif.reg_write  = 1'b1;
                    cif.mem_to_reg = M2R_MDR;
                    cif.instr_done = 1'b1;
                end
                ST_BRANCH: begin
                    cif.alu_src_a  = SRCA_REG;
                    cif.alu_op     = ALU_SUB;
                    cif.pc_src     = PCSRC_ALUOUT;
                    cif.pc_write   = cif.zero;
                    cif.instr_done = 1'b1;
                end
                ST_JUMP: begin
                    cif.pc_write   = 1'b1;
                    cif.pc_src     = PCSRC_JUMP;
                    cif.instr_done = 1'b1;
                    if (op_q == OP_JAL) begin
                        cif.reg_write  = 1'b1;
                        cif.reg_dst    = REGDST_R31;
                        cif.mem_to_reg = M2R_PC;
                    end
                end
                ST_FAULT: cif.sign_or_zero = 1'b0;
                default: ;
            endcase
        end
    end

    assign cif.mem_fault = fault_q;
    assign state         = STATE_W'(st);

endmodule
